// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over one shared
// req/ready memory port and counts retired instructions. Define ILLEGAL_TRAP_EN to trap on illegal opcodes.
module multicycle_controller #(
  parameter int CNT_W  = 32,
  parameter bit ONEHOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_LUI, S_TRAP
  } state_e;

  // The enum only names the states; the register encoding is chosen by ONEHOT.
  localparam int SW = ONEHOT ? 16 : 4;

  function automatic logic [SW-1:0] enc(input state_e s);
    if (ONEHOT) return SW'(1) << s;
    else        return SW'(s);
  endfunction

  localparam logic [SW-1:0] ST_IDLE     = enc(S_IDLE);
  localparam logic [SW-1:0] ST_FETCH    = enc(S_FETCH);
  localparam logic [SW-1:0] ST_DECODE   = enc(S_DECODE);
  localparam logic [SW-1:0] ST_MEMADR   = enc(S_MEMADR);
  localparam logic [SW-1:0] ST_MEMREAD  = enc(S_MEMREAD);
  localparam logic [SW-1:0] ST_MEMWB    = enc(S_MEMWB);
  localparam logic [SW-1:0] ST_MEMWRITE = enc(S_MEMWRITE);
  localparam logic [SW-1:0] ST_EXECR    = enc(S_EXECR);
  localparam logic [SW-1:0] ST_EXECI    = enc(S_EXECI);
  localparam logic [SW-1:0] ST_ALUWB    = enc(S_ALUWB);
  localparam logic [SW-1:0] ST_BRANCH   = enc(S_BRANCH);
  localparam logic [SW-1:0] ST_JAL      = enc(S_JAL);
  localparam logic [SW-1:0] ST_JALR     = enc(S_JALR);
  localparam logic [SW-1:0] ST_LINK     = enc(S_LINK);
  localparam logic [SW-1:0] ST_LUI      = enc(S_LUI);
  localparam logic [SW-1:0] ST_TRAP     = enc(S_TRAP);

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECR;
          OP_ITYPE:          state_d = ST_EXECI;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          OP_JALR:           state_d = ST_JALR;
          OP_LUI:            state_d = ST_LUI;
          OP_AUIPC:          state_d = ST_ALUWB;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = ST_TRAP;
`else
          default:           state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JAL:      state_d = ST_ALUWB;
      ST_JALR:     state_d = ST_LINK;
      ST_LINK:     state_d = ST_FETCH;
      ST_LUI:      state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        // PC+4 is computed and written back in the same cycle the instruction arrives.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
        end
      end
      ST_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      ST_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      ST_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      ST_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      ST_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ST_ALUWB:  reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      ST_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      ST_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      ST_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
      end
      ST_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:         imm_src = 3'b001;
      OP_BRANCH:        imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  // Staying in FETCH while waiting, or leaving IDLE, does not retire anything.
  assign retire    = (state_d == ST_FETCH) && (state_q != ST_IDLE) && (state_q != ST_FETCH);
  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == ST_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: binary and one-hot instances run side by side
// against a per-instruction cycle-sequence model built from the instruction class.
module tb_multicycle_controller;

  localparam int CW = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;

  logic binReq, binAdr, binMw, binIr, binPc, binBr, binRw, binIll;
  logic [1:0] binRs, binA, binB, binOp;
  logic [2:0] binImm;
  logic [CW-1:0] binCnt;
  logic hotReq, hotAdr, hotMw, hotIr, hotPc, hotBr, hotRw, hotIll;
  logic [1:0] hotRs, hotA, hotB, hotOp;
  logic [2:0] hotImm;
  logic [CW-1:0] hotCnt;
  logic [15:0] binCtl, hotCtl;

  int checks = 0;
  int passes = 0;
  logic [CW-1:0] expCnt;
  logic [15:0] expQ[$];
  bit rdyQ[$];
  logic [6:0] opList[9] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CW), .ONEHOT(1'b0)) dutBin (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(binReq), .adr_src(binAdr), .mem_write(binMw), .ir_write(binIr),
    .pc_write(binPc), .branch(binBr), .reg_write(binRw), .result_src(binRs),
    .alu_src_a(binA), .alu_src_b(binB), .alu_op(binOp), .imm_src(binImm),
    .instret(binCnt), .illegal(binIll)
  );

  multicycle_controller #(.CNT_W(CW), .ONEHOT(1'b1)) dutHot (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(hotReq), .adr_src(hotAdr), .mem_write(hotMw), .ir_write(hotIr),
    .pc_write(hotPc), .branch(hotBr), .reg_write(hotRw), .result_src(hotRs),
    .alu_src_a(hotA), .alu_src_b(hotB), .alu_op(hotOp), .imm_src(hotImm),
    .instret(hotCnt), .illegal(hotIll)
  );

  // Pack every control output into one word: illegal, req, adr, mw, ir, pc, br, rw, rs, a, b, op.
  assign binCtl = {binIll, binReq, binAdr, binMw, binIr, binPc, binBr, binRw, binRs, binA, binB, binOp};
  assign hotCtl = {hotIll, hotReq, hotAdr, hotMw, hotIr, hotPc, hotBr, hotRw, hotRs, hotA, hotB, hotOp};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [15:0] cw(input bit req, input bit adr, input bit mw, input bit ir,
                                     input bit pc, input bit br, input bit rw, input logic [1:0] rs,
                                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    return {1'b0, req, adr, mw, ir, pc, br, rw, rs, a, b, op};
  endfunction

  function automatic logic [2:0] immFor(input logic [6:0] op);
    if (op == OP_STORE) return 3'b001;
    if (op == OP_BRANCH) return 3'b010;
    if (op == OP_JAL) return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic void pushCyc(input logic [15:0] w, input bit r);
    expQ.push_back(w);
    rdyQ.push_back(r);
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  // Runs one instruction starting in FETCH; memory waits stretch the fetch and data accesses.
  task automatic applyStimulus(input logic [6:0] op, input int fetchWait, input int memWait);
    logic [15:0] aluWb, trapW;
    bit trapped;
    trapped = 1'b0;
    aluWb = cw(0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00);
    trapW = 16'h8000;
    expQ.delete();
    rdyQ.delete();
    for (int i = 0; i < fetchWait; i++) pushCyc(cw(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
    pushCyc(cw(1,0,0,1,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00), 1'b1);
    pushCyc(cw(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00), rnd());
    case (op)
      OP_LOAD: begin
        pushCyc(cw(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00), rnd());
        for (int i = 0; i < memWait; i++) pushCyc(cw(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
        pushCyc(cw(1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1);
        pushCyc(cw(0,0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00), rnd());
      end
      OP_STORE: begin
        pushCyc(cw(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00), rnd());
        for (int i = 0; i < memWait; i++) pushCyc(cw(1,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0);
        pushCyc(cw(1,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1);
      end
      OP_RTYPE: begin
        pushCyc(cw(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10), rnd());
        pushCyc(aluWb, rnd());
      end
      OP_ITYPE: begin
        pushCyc(cw(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10), rnd());
        pushCyc(aluWb, rnd());
      end
      OP_BRANCH: pushCyc(cw(0,0,0,0,0,1,0, 2'b00, 2'b10, 2'b00, 2'b01), rnd());
      OP_JAL: begin
        pushCyc(cw(0,0,0,0,1,0,0, 2'b00, 2'b01, 2'b10, 2'b00), rnd());
        pushCyc(aluWb, rnd());
      end
      OP_JALR: begin
        pushCyc(cw(0,0,0,0,1,0,0, 2'b10, 2'b10, 2'b01, 2'b00), rnd());
        pushCyc(cw(0,0,0,0,0,0,1, 2'b10, 2'b01, 2'b10, 2'b00), rnd());
      end
      OP_LUI: pushCyc(cw(0,0,0,0,0,0,1, 2'b11, 2'b00, 2'b00, 2'b00), rnd());
      OP_AUIPC: pushCyc(aluWb, rnd());
      default: begin
`ifdef ILLEGAL_TRAP_EN
        trapped = 1'b1;
        for (int i = 0; i < 4; i++) pushCyc(trapW, rnd());
`endif
      end
    endcase
    foreach (expQ[i]) begin
      opcode = op;
      mem_ready = rdyQ[i];
      #1;
      checkOutput($sformatf("ctl_bin op=%b cyc=%0d", op, i), binCtl, expQ[i]);
      checkOutput($sformatf("ctl_hot op=%b cyc=%0d", op, i), hotCtl, expQ[i]);
      checkOutput($sformatf("imm_bin op=%b cyc=%0d", op, i), binImm, immFor(op));
      checkOutput($sformatf("imm_hot op=%b cyc=%0d", op, i), hotImm, immFor(op));
      @(posedge clk);
      #1;
    end
    if (!trapped) expCnt = expCnt + 1'b1;
    checkOutput($sformatf("instret_bin op=%b", op), binCnt, expCnt);
    checkOutput($sformatf("instret_hot op=%b", op), hotCnt, expCnt);
  endtask

  // Asserts reset, checks the reset and IDLE outputs, and leaves both DUTs entering FETCH.
  task automatic doReset();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    expCnt = '0;
    checkOutput("rst_ctl_bin", binCtl, 16'h0000);
    checkOutput("rst_ctl_hot", hotCtl, 16'h0000);
    checkOutput("rst_cnt_bin", binCnt, expCnt);
    checkOutput("rst_cnt_hot", hotCnt, expCnt);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = rnd();
    #1;
    checkOutput("idle_ctl_bin", binCtl, 16'h0000);
    checkOutput("idle_ctl_hot", hotCtl, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    opcode = OP_ITYPE;
    mem_ready = 1'b0;
    expCnt = '0;
    @(posedge clk);
    #1;
    doReset();

    applyStimulus(OP_ITYPE, 0, 0);
    applyStimulus(OP_LOAD, 0, 3);
    applyStimulus(OP_STORE, 1, 1);
    applyStimulus(OP_BRANCH, 0, 0);
    applyStimulus(OP_JAL, 0, 0);
    applyStimulus(OP_JALR, 2, 0);
    applyStimulus(OP_LUI, 0, 0);
    applyStimulus(OP_AUIPC, 0, 0);
    applyStimulus(OP_RTYPE, 0, 0);

    for (int n = 0; n < 40; n++)
      applyStimulus(opList[$urandom_range(8, 0)], int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));

    // Reset while the fetch is still waiting on memory.
    opcode = OP_ITYPE;
    mem_ready = 1'b0;
    #1;
    checkOutput("fetchwait_req_bin", binReq, 1'b1);
    checkOutput("fetchwait_req_hot", hotReq, 1'b1);
    #2;
    doReset();

    for (int n = 0; n < 15; n++)
      applyStimulus(opList[$urandom_range(8, 0)], int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
    checkOutput("wrap15_bin", binCnt, 15);
    checkOutput("wrap15_hot", hotCnt, 15);
    applyStimulus(OP_LUI, 0, 0);
    checkOutput("wrap0_bin", binCnt, 0);
    checkOutput("wrap0_hot", hotCnt, 0);

    applyStimulus(7'b0000000, 0, 0);
    applyStimulus(OP_ITYPE, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Sequential control unit for the multicycle RV32I core. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles. All instruction and data traffic goes through one shared memory port using a req/ready handshake. It also maintains a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)
ONEHOT, 0, state encoding: 0 = binary, 1 = one-hot; must not change behaviour

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instr[6:0] from instruction register
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
adr_src  output  1  0 = PC, 1 = ALUOut as memory address
mem_write  output  1  store strobe (valid with mem_req)
ir_write  output  1  latch instruction register
pc_write  output  1  unconditional PC load
branch  output  1  PC loads if datapath branch condition true
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut, 01 mem data, 10 ALUResult, 11 ImmExt
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  output  2  00 rs2, 01 ImmExt, 10 constant 4
alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from opcode in all states
instret  output  CNT_W  retired instruction count
illegal  output  1  illegal-opcode flag (see optional feature)

Behaviour:
- Reset (async): state goes to IDLE, instret = 0, illegal = 0. IDLE drives every control output 0 (imm_src still decoded). IDLE -> FETCH on the first clock after reset deasserts.
- Reset asserted mid-access drops mem_req immediately. Any partially retired instruction is not counted.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, adr_src=0. Hold in FETCH while mem_ready=0.
  - When mem_ready=1 (Mealy, same cycle): ir_write=1, pc_write=1, a=00, b=10, alu_op=00, result_src=10. Then go to DECODE.
- DECODE: a=01, b=01, alu_op=00, so ALUOut = OldPC+imm. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB (auipc)
  - anything else -> illegal handling
- MEMADR: a=10, b=01, alu_op=00. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, all held until mem_ready. Then FETCH.
- EXECR: a=10, b=00, alu_op=10. Then ALUWB.
- EXECI: a=10, b=01, alu_op=10. Then ALUWB.
- ALUWB: result_src=00, reg_write=1. Then FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1. Then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, so ALUOut latches OldPC+4. Then ALUWB.
- JALR: a=10, b=01, alu_op=00, result_src=10, pc_write=1. Clearing the target LSB is the datapath's job. Then LINK.
- LINK: a=01, b=10, alu_op=00, result_src=10, reg_write=1. Then FETCH.
- LUI: result_src=11, reg_write=1. Then FETCH.
- instret increments by 1 on every transition into FETCH from a non-IDLE state, and wraps at 2^CNT_W-1 -> 0.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - R/I-type 4 cycles
  - load 5 cycles
  - store 4 cycles
  - branch 3 cycles
  - jal 4 cycles
  - jalr 4 cycles
  - lui 3 cycles
  - auipc 3 cycles
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to TRAP. TRAP drives all control outputs 0, sets illegal=1, and stays there until reset. instret is not incremented.
- Undefined: an illegal opcode goes DECODE -> FETCH as a NOP. instret increments. illegal is tied 0.

Test Plan:
- Reset, release, mem_ready=1 always, addi (0010011) -> FETCH/DECODE/EXECI/ALUWB. reg_write=1 only in cycle 4; instret 0 -> 1.
- lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> mem_req=1, adr_src=1 held 4 cycles, then MEMWB with result_src=01, reg_write=1.
- sw (0100011) -> mem_write=1 and mem_req=1 only in MEMWRITE. reg_write never 1; returns to FETCH; instret +1.
- beq, then jal, then jalr -> branch=1 once. jal asserts pc_write in JAL then reg_write in ALUWB. jalr asserts pc_write in JALR then reg_write in LINK with result_src=10.
- instret preloaded near wrap (CNT_W=4, 15 instructions then 1 more) -> reads 15 then 0.
- Reset asserted during FETCH wait -> mem_req drops the same cycle and instret=0. Opcode 0000000 -> TRAP with illegal=1 if ILLEGAL_TRAP_EN, otherwise a NOP.
